// File: rtl/lcd_frame_fill_if.sv
// Frame-RAM port-A write bus and the frame-ready strobe to the LCD engine.
interface lcd_frame_fill_if #(
    parameter int ADDR_W = 17
);
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [15:0]       dina;
    logic              data_flag;

    modport master (
        output wea,
        output addra,
        output dina,
        output data_flag
    );

    modport slave (
        input wea,
        input addra,
        input dina,
        input data_flag
    );
endinterface

// File: rtl/lcd_frame_fill.sv
// Raster-order frame renderer: background fill with one rectangle overlay,
// followed by a frame-ready pulse and a holdoff covering the LCD transfer.
module lcd_frame_fill #(
    parameter int H_PIX       = 240,
    parameter int V_PIX       = 320,
    parameter int ADDR_W      = 17,
    parameter int HOLD_CYCLES = 16_600_000
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    start,
    input  logic [15:0]             bg_color,
    input  logic [15:0]             fg_color,
    input  logic [7:0]              rect_x0,
    input  logic [7:0]              rect_x1,
    input  logic [8:0]              rect_y0,
    input  logic [8:0]              rect_y1,
    output logic                    busy,
    lcd_frame_fill_if.master        ram
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIX * V_PIX - 1);
    localparam logic [7:0]        X_LAST    = 8'(H_PIX - 1);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_FILL = 4'b0010,
        S_DONE = 4'b0100,
        S_HOLD = 4'b1000
    } state_t;

    state_t            r_state;
    logic [7:0]        r_x;
    logic [8:0]        r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [HW-1:0]     r_hcnt;

    logic [15:0]       r_bg;
    logic [15:0]       r_fg;
    logic [7:0]        r_x0;
    logic [7:0]        r_x1;
    logic [8:0]        r_y0;
    logic [8:0]        r_y1;

    logic              r_busy;
    logic              r_wea;
    logic [ADDR_W-1:0] r_addra;
    logic [15:0]       r_dina;
    logic              r_flag;

    logic              w_in_x;
    logic              w_in_y;
    logic [15:0]       w_pix;
    logic              w_x_wrap;
    logic              w_last;
    logic              w_hold_end;

    // An inverted bound (x0>x1 or y0>y1) makes the range test false for
    // every coordinate, so the empty rectangle needs no special case.
    assign w_in_x     = (r_x >= r_x0) && (r_x <= r_x1);
    assign w_in_y     = (r_y >= r_y0) && (r_y <= r_y1);
    assign w_pix      = (w_in_x && w_in_y) ? r_fg : r_bg;
    assign w_x_wrap   = (r_x == X_LAST);
    assign w_last     = (r_addr == LAST_ADDR);
    assign w_hold_end = (r_hcnt == HOLD_LAST);

    assign busy          = r_busy;
    assign ram.wea       = r_wea;
    assign ram.addra     = r_addra;
    assign ram.dina      = r_dina;
    assign ram.data_flag = r_flag;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_hcnt  <= '0;
            r_bg    <= '0;
            r_fg    <= '0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_busy  <= 1'b0;
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_dina  <= '0;
            r_flag  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_wea  <= 1'b0;
                    r_flag <= 1'b0;
                    if (start) begin
                        r_bg    <= bg_color;
                        r_fg    <= fg_color;
                        r_x0    <= rect_x0;
                        r_x1    <= rect_x1;
                        r_y0    <= rect_y0;
                        r_y1    <= rect_y1;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_wea   <= 1'b1;
                    r_addra <= r_addr;
                    r_dina  <= w_pix;
                    r_addr  <= r_addr + ADDR_W'(1);
                    // addr tracks y*H_PIX+x because both advance together.
                    if (w_x_wrap) begin
                        r_x <= '0;
                        r_y <= r_y + 9'd1;
                    end else begin
                        r_x <= r_x + 8'd1;
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_wea   <= 1'b0;
                    r_flag  <= 1'b1;
                    r_hcnt  <= '0;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    r_wea  <= 1'b0;
                    r_flag <= 1'b0;
                    if (w_hold_end) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hcnt <= r_hcnt + HW'(1);
                    end
                end
                default: begin
                    r_wea   <= 1'b0;
                    r_flag  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_fill.sv
// Bench for lcd_frame_fill on a reduced 40x30 frame with a short holdoff.
module tb_lcd_frame_fill;

    localparam int H    = 40;
    localparam int V    = 30;
    localparam int NPIX = H * V;
    localparam int HOLD = 10;
    localparam int AW   = 17;

    typedef struct {
        logic [15:0] bg;
        logic [15:0] fg;
        int          x0;
        int          x1;
        int          y0;
        int          y1;
        int          exp_fg;
        bit          noise;
    } vec_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic [15:0] bg_color;
    logic [15:0] fg_color;
    logic [7:0]  rect_x0;
    logic [7:0]  rect_x1;
    logic [8:0]  rect_y0;
    logic [8:0]  rect_y1;
    logic        busy;

    lcd_frame_fill_if #(.ADDR_W(AW)) ram_if ();

    lcd_frame_fill #(
        .H_PIX      (H),
        .V_PIX      (V),
        .ADDR_W     (AW),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .start    (start),
        .bg_color (bg_color),
        .fg_color (fg_color),
        .rect_x0  (rect_x0),
        .rect_x1  (rect_x1),
        .rect_y0  (rect_y0),
        .rect_y1  (rect_y1),
        .busy     (busy),
        .ram      (ram_if)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int          n_chk;
    int          n_err;
    logic [15:0] mem [NPIX];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_pix(input int a, input vec_t v);
        int x;
        int y;
        x = a % H;
        y = a / H;
        if (x >= v.x0 && x <= v.x1 && y >= v.y0 && y <= v.y1)
            return v.fg;
        return v.bg;
    endfunction

    function automatic int model_fg_count(input vec_t v);
        int n;
        n = 0;
        for (int a = 0; a < NPIX; a++)
            if (model_pix(a, v) == v.fg) n++;
        return n;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.fg     = 16'($urandom);
        v.bg     = v.fg ^ 16'h5A5A;
        v.x0     = $urandom_range(0, 50);
        v.x1     = $urandom_range(0, 50);
        v.y0     = $urandom_range(0, 35);
        v.y1     = $urandom_range(0, 35);
        v.noise  = 1'b1;
        v.exp_fg = model_fg_count(v);
        return v;
    endfunction

    task automatic set_inputs(input vec_t v);
        bg_color = v.bg;
        fg_color = v.fg;
        rect_x0  = 8'(v.x0);
        rect_x1  = 8'(v.x1);
        rect_y0  = 9'(v.y0);
        rect_y1  = 9'(v.y1);
    endtask

    task automatic scramble_inputs();
        bg_color = 16'($urandom);
        fg_color = 16'($urandom);
        rect_x0  = 8'($urandom);
        rect_x1  = 8'($urandom);
        rect_y0  = 9'($urandom);
        rect_y1  = 9'($urandom);
    endtask

    task automatic begin_frame(input vec_t v);
        set_inputs(v);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        chk("latch_busy", busy, 1);
        chk("latch_wea", ram_if.wea, 0);
        scramble_inputs();
    endtask

    task automatic collect(input vec_t v);
        int          nw;
        int          bad_a;
        int          bad_p;
        int          nfl;
        int          nfg;
        int          cyc;
        bit          prev_last;
        bit          flag_ok;
        logic [15:0] e;
        nw = 0; bad_a = 0; bad_p = 0; nfl = 0; nfg = 0; cyc = 0;
        prev_last = 1'b0; flag_ok = 1'b0;
        while (nfl == 0 && cyc < NPIX + 50) begin
            @(negedge sys_clk);
            cyc++;
            if (v.noise) begin
                start = 1'($urandom);
                scramble_inputs();
            end
            if (ram_if.wea) begin
                if (ram_if.addra != AW'(nw)) bad_a++;
                e = model_pix(nw, v);
                if (ram_if.dina !== e) bad_p++;
                if (ram_if.dina == v.fg) nfg++;
                if (ram_if.addra < AW'(NPIX)) mem[ram_if.addra] = ram_if.dina;
                nw++;
            end
            if (ram_if.data_flag) begin
                nfl++;
                flag_ok = !ram_if.wea && prev_last;
            end
            prev_last = ram_if.wea && (ram_if.addra == AW'(NPIX - 1));
        end
        start = 1'b0;
        chk("write_count", nw, NPIX);
        chk("addr_seq_bad", bad_a, 0);
        chk("pixel_bad", bad_p, 0);
        chk("flag_count", nfl, 1);
        chk("flag_after_last", flag_ok, 1);
        chk("fg_writes", nfg, v.exp_fg);
    endtask

    task automatic hold_check(input bit noise, input bit reenter);
        int bh;
        int q;
        bh = 1;
        q  = 0;
        for (int i = 0; i < HOLD + 20; i++) begin
            @(negedge sys_clk);
            if (ram_if.data_flag || ram_if.wea) q++;
            if (!busy) break;
            bh++;
            start = reenter ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
        end
        start = reenter;
        chk("hold_len", bh, HOLD);
        chk("hold_quiet", q, 0);
        if (!reenter) begin
            repeat (3) @(negedge sys_clk);
            chk("idle_quiet", {busy, ram_if.wea, ram_if.data_flag}, 0);
        end
    endtask

    vec_t tbl [8];
    vec_t v;
    vec_t v2;
    int   found;
    int   q;

    initial begin
        n_chk = 0;
        n_err = 0;
        tbl[0] = '{16'h001F, 16'h07E0,  5,   4,  0,  29,    0, 1'b0};
        tbl[1] = '{16'h0000, 16'hF800, 10,  19, 20,  29,  100, 1'b1};
        tbl[2] = '{16'h1234, 16'hABCD,  0,  39, 29, 400,   40, 1'b0};
        tbl[3] = '{16'h0F0F, 16'hF0F0, 35, 255,  0,   0,    5, 1'b1};
        tbl[4] = '{16'h2222, 16'hDDDD,  0,  10, 20,  10,    0, 1'b0};
        tbl[5] = '{16'h3333, 16'hCCCC,  0,   0,  0,   0,    1, 1'b1};
        tbl[6] = '{16'h4444, 16'hBBBB,  0, 255,  0, 511, NPIX, 1'b0};
        tbl[7] = '{16'h5555, 16'hAAAA, 40, 200,  0,  29,    0, 1'b1};

        sys_rst_n = 1'b0;
        start     = 1'b1;
        scramble_inputs();
        q = 0;
        repeat (5) begin
            @(negedge sys_clk);
            if ({busy, ram_if.wea, ram_if.addra, ram_if.dina, ram_if.data_flag} != 0) q++;
        end
        chk("reset_outputs_nonzero", q, 0);
        start = 1'b0;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("after_reset_idle", {busy, ram_if.wea, ram_if.data_flag}, 0);

        for (int i = 0; i < 8; i++) begin
            begin_frame(tbl[i]);
            collect(tbl[i]);
            if (i == 1) begin
                chk("spot_x10_y20", mem[20 * H + 10], 16'hF800);
                chk("spot_x9_y20", mem[20 * H + 9], 16'h0000);
                chk("spot_x19_y29", mem[29 * H + 19], 16'hF800);
                chk("spot_x20_y29", mem[29 * H + 20], 16'h0000);
            end
            if (i == 2) begin
                chk("edge_last_line_first", mem[(V - 1) * H], 16'hABCD);
                chk("edge_line_above", mem[(V - 1) * H - 1], 16'h1234);
            end
            hold_check(tbl[i].noise, 1'b0);
        end

        v  = rand_vec();
        v2 = rand_vec();
        begin_frame(v);
        collect(v);
        set_inputs(v2);
        hold_check(1'b0, 1'b1);
        @(negedge sys_clk);
        chk("reenter_busy", busy, 1);
        chk("reenter_wea", ram_if.wea, 0);
        start = 1'b0;
        scramble_inputs();
        collect(v2);
        hold_check(1'b1, 1'b0);

        v = rand_vec();
        begin_frame(v);
        found = 0;
        for (int i = 0; i < NPIX + 10; i++) begin
            @(negedge sys_clk);
            if (ram_if.wea && ram_if.addra == AW'(1000)) begin
                found = 1;
                break;
            end
        end
        chk("reached_addr_1000", found, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {busy, ram_if.wea, ram_if.addra, ram_if.dina, ram_if.data_flag}, 0);
        q = 0;
        repeat (4) begin
            @(negedge sys_clk);
            if (ram_if.wea || ram_if.data_flag || busy) q++;
        end
        chk("reset_hold_quiet", q, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("post_abort_idle", {busy, ram_if.data_flag}, 0);

        v = rand_vec();
        begin_frame(v);
        collect(v);
        hold_check(1'b1, 1'b0);

        for (int i = 0; i < 2; i++) begin
            v = rand_vec();
            begin_frame(v);
            collect(v);
            hold_check(1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
